// File: rtl/gs_mul_sched.sv
`default_nettype none
// ============================================================================
//  Module   : gs_mul_sched
//  Purpose  : Goldschmidt divider iteration sequencer. Owns the shared
//             pipelined W x W multiplier, issues N*F then D*F each iteration
//             (F = 2 - D), tracks the multiplier latency, captures both
//             products and returns the final N as the quotient.
//  Revision : 1.0  initial release
// ============================================================================
module gs_mul_sched #(
   parameter int W       = 24,   // operand width, Q1.(W-1)
   parameter int ITERS   = 4,    // Goldschmidt iterations, >= 1
   parameter int MUL_LAT = 4     // operands-to-product latency, >= 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [W-1:0]     n_in,
   input  logic [W-1:0]     d_in,
   output logic             busy,
   output logic             done,
   output logic [W-1:0]     q_out,
   output logic             err,
   output logic [W-1:0]     mul_a,
   output logic [W-1:0]     mul_x,
   input  logic [2*W-1:0]   mul_p
);

   // Iteration counter holds 0..ITERS-1; phase counter spans one full
   // iteration (ISSUE_N = 0, ISSUE_D = 1, WAIT = 2..MUL_LAT+1).
   localparam int IW = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam int PW = $clog2(MUL_LAT + 2);

   localparam logic [PW-1:0] c_cap_phase  = PW'(MUL_LAT);
   localparam logic [PW-1:0] c_last_phase = PW'(MUL_LAT + 1);
   localparam logic [IW-1:0] c_last_iter  = IW'(ITERS - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE_N = 3'd1,
      S_ISSUE_D = 3'd2,
      S_WAIT    = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [W-1:0]     r_n;
   logic [W-1:0]     r_d;
   logic [W-1:0]     r_n_next;
   logic [W-1:0]     r_q;
   logic             r_err;
   logic [IW-1:0]    r_iter;
   logic [PW-1:0]    r_phase;

   logic             w_idle_like;
   logic             w_accept;
   logic             w_dzero;
   logic             w_in_iter;
   logic             w_last_phase;
   logic             w_last_iter;
   logic             w_iter_end;
   logic [W-1:0]     w_f;
   logic [W-1:0]     w_prod;
   logic             w_unused_mul_bits;

   // Start is only honoured when not busy (IDLE or the DONE cycle).
   assign w_idle_like  = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_accept     = start && w_idle_like;
   assign w_dzero      = (d_in == '0);
   assign w_in_iter    = (r_state == S_ISSUE_N) || (r_state == S_ISSUE_D) ||
                         (r_state == S_WAIT);
   assign w_last_phase = (r_phase == c_last_phase);
   assign w_last_iter  = (r_iter == c_last_iter);
   assign w_iter_end   = (r_state == S_WAIT) && w_last_phase;

   // F = 2 - D in Q1.(W-1) is simply the two's-complement negate of D.
   assign w_f = ~r_d + W'(1);

   // Q1.(W-1) x Q1.(W-1) = Q2.(2W-2): drop the top bit (mod-2 wrap) and
   // truncate the low W-1 fraction bits.
   assign w_prod            = mul_p[2*W-2 -: W];
   assign w_unused_mul_bits = ^{mul_p[2*W-1], mul_p[W-2:0]};

   assign busy  = w_in_iter;
   assign done  = (r_state == S_DONE);
   assign q_out = r_q;
   assign err   = r_err;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_next = w_dzero ? S_DONE : S_ISSUE_N;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_ISSUE_N: w_state_next = S_ISSUE_D;
         S_ISSUE_D: w_state_next = S_WAIT;
         S_WAIT: begin
            if (w_last_phase) begin
               w_state_next = w_last_iter ? S_DONE : S_ISSUE_N;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Multiplier operands come only from state and the N/D registers, so
   // nothing on the divider inputs reaches the multiplier combinationally.
   always_comb begin
      mul_a = '0;
      mul_x = '0;
      case (r_state)
         S_ISSUE_N: begin
            mul_a = r_n;
            mul_x = w_f;
         end
         S_ISSUE_D: begin
            mul_a = r_d;
            mul_x = w_f;
         end
         default: ;
      endcase
   end

   // Operand load, iteration/phase counting, product capture and result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_n      <= '0;
         r_d      <= '0;
         r_n_next <= '0;
         r_q      <= '0;
         r_err    <= 1'b0;
         r_iter   <= '0;
         r_phase  <= '0;
      end else begin
         if (w_accept) begin
            if (w_dzero) begin
               // Divide by zero: report immediately, no multiplies.
               r_q   <= '1;
               r_err <= 1'b1;
            end else begin
               r_n     <= n_in;
               r_d     <= d_in;
               r_iter  <= '0;
               r_phase <= '0;
            end
         end else if (w_in_iter) begin
            r_phase <= w_last_phase ? '0 : r_phase + 1'b1;
         end

         // N*F emerges MUL_LAT cycles after ISSUE_N; capture is keyed on the
         // phase counter alone, so stale pipeline contents are never taken.
         if (w_in_iter && (r_phase == c_cap_phase)) begin
            r_n_next <= w_prod;
         end

         // D*F arrives one cycle later; close out the iteration.
         if (w_iter_end) begin
            r_n    <= r_n_next;
            r_d    <= w_prod;
            r_iter <= r_iter + 1'b1;
            if (w_last_iter) begin
               r_q   <= r_n_next;
               r_err <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gs_mul_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gs_mul_sched
//  Purpose  : Self-checking bench for gs_mul_sched with a behavioural
//             pipelined multiplier and result/issue scoreboards.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gs_mul_sched;

   localparam int W       = 24;
   localparam int ITERS   = 4;
   localparam int MUL_LAT = 4;
   localparam int P       = MUL_LAT + 2;

   typedef struct {
      logic [W-1:0] q;
      logic         err;
      int           done_cyc;
      logic [W-1:0] dfin;
      bit           has_d;
      int           n_issue;
   } sb_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] x;
      int           cyc;
   } iss_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [W-1:0]   n_in = '0;
   logic [W-1:0]   d_in = '0;
   logic           busy;
   logic           done;
   logic [W-1:0]   q_out;
   logic           err;
   logic [W-1:0]   mul_a;
   logic [W-1:0]   mul_x;
   logic [2*W-1:0] mul_p;

   logic [2*W-1:0] pipe [MUL_LAT];

   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   done_seen = 0;
   int   issue_cnt = 0;
   sb_t  sb_q[$];
   iss_t iss_q[$];

   gs_mul_sched #(.W(W), .ITERS(ITERS), .MUL_LAT(MUL_LAT)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .n_in  (n_in),
      .d_in  (d_in),
      .busy  (busy),
      .done  (done),
      .q_out (q_out),
      .err   (err),
      .mul_a (mul_a),
      .mul_x (mul_x),
      .mul_p (mul_p)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural multiplier: MUL_LAT register stages, never reset.
   always @(posedge clk) begin
      pipe[0] <= {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_x};
      for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign mul_p = pipe[MUL_LAT-1];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] qmul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      return p[2*W-2 -: W];
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Drive a start in the current cycle (cycle 0) and push the expected
   // issues and result; returns positioned in cycle 1.
   task automatic do_start(input logic [W-1:0] n, input logic [W-1:0] d);
      sb_t          e;
      iss_t         ie;
      logic [W-1:0] nn, dd, f;
      if (d == '0) begin
         e.q = '1; e.err = 1'b1; e.done_cyc = cyc + 1;
         e.dfin = '0; e.has_d = 1'b0; e.n_issue = 0;
      end else begin
         nn = n; dd = d;
         for (int k = 0; k < ITERS; k++) begin
            f = ~dd + W'(1);
            ie.a = nn; ie.x = f; ie.cyc = cyc + 1 + k*P; iss_q.push_back(ie);
            ie.a = dd; ie.x = f; ie.cyc = cyc + 2 + k*P; iss_q.push_back(ie);
            nn = qmul(nn, f);
            dd = qmul(dd, f);
         end
         e.q = nn; e.err = 1'b0; e.done_cyc = cyc + 1 + ITERS*P;
         e.dfin = dd; e.has_d = 1'b1; e.n_issue = 2*ITERS;
      end
      sb_q.push_back(e);
      n_in = n; d_in = d; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int k = 0; k < 200; k++) begin
         if (done) return;
         step();
      end
      check({tag, "_timeout"}, 0, 1);
   endtask

   // Monitor: compares multiplier issues and done results against the queues.
   initial begin
      sb_t  e;
      iss_t ie;
      forever begin
         @(negedge clk);
         if (rst) begin
            sb_q.delete();
            iss_q.delete();
            issue_cnt = 0;
         end else begin
            if (mul_a != '0 || mul_x != '0) begin
               issue_cnt++;
               if (iss_q.size() == 0) begin
                  check("issue_unexpected", {mul_a, mul_x}, 0);
               end else begin
                  ie = iss_q.pop_front();
                  check("issue_a", mul_a, ie.a);
                  check("issue_x", mul_x, ie.x);
                  check("issue_cyc", cyc, ie.cyc);
               end
            end
            if (done) begin
               done_seen++;
               if (sb_q.size() == 0) begin
                  check("done_unexpected", 1, 0);
               end else begin
                  e = sb_q.pop_front();
                  check("q_out", q_out, e.q);
                  check("err", err, e.err);
                  check("done_cyc", cyc, e.done_cyc);
                  check("issue_count", issue_cnt, e.n_issue);
                  if (e.has_d) check("d_final", dut.r_d, e.dfin);
                  issue_cnt = 0;
               end
            end
         end
      end
   end

   // Stimulus.
   initial begin
      logic [W-1:0] old_q;
      bit           hold_ok;
      int           ds;

      // Reset state.
      step(); step();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_q", q_out, 0);
      check("rst_err", err, 0);
      check("rst_mul_a", mul_a, 0);
      check("rst_mul_x", mul_x, 0);
      rst = 1'b0;
      step(); step();

      // Basic quotient 0.75 / 0.5 and first issue pair.
      do_start(24'h600000, 24'h400000);
      check("pair0_a", mul_a, 24'h600000);
      check("pair0_x", mul_x, 24'hC00000);
      check("busy_c1", busy, 1);
      step();
      check("pair1_a", mul_a, 24'h400000);
      check("pair1_x", mul_x, 24'hC00000);
      wait_done("basic");
      check("basic_q", q_out, 24'hBFFF40);
      check("basic_err", err, 0);
      check("basic_dfin", dut.r_d, 24'h7FFF80);
      check("busy_in_done", busy, 0);

      // Divide by zero, started back-to-back in the DONE cycle.
      do_start(24'h123456, 24'h000000);
      wait_done("dz");
      check("dz_q", q_out, 24'hFFFFFF);
      check("dz_err", err, 1);

      // Start while busy at cycle 5 is ignored.
      do_start(24'h600000, 24'h400000);
      step(); step(); step(); step();
      n_in = 24'h200000; d_in = 24'h700000; start = 1'b1;
      step();
      start = 1'b0;
      wait_done("ignored");
      check("ignored_q", q_out, 24'hBFFF40);

      // Back-to-back: start in the DONE cycle, q_out holds until new done.
      old_q = q_out;
      do_start(24'h400000, 24'h600000);
      check("b2b_busy", busy, 1);
      hold_ok = 1'b1;
      for (int k = 0; k < 200 && !done; k++) begin
         if (q_out !== old_q) hold_ok = 1'b0;
         step();
      end
      check("b2b_hold", hold_ok, 1);
      check("b2b_done", done, 1);

      // Asynchronous reset mid-WAIT at cycle 10.
      do_start(24'h600000, 24'h400000);
      for (int k = 1; k < 10; k++) step();
      rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_q", q_out, 0);
      check("arst_err", err, 0);
      check("arst_mul_a", mul_a, 0);
      check("arst_mul_x", mul_x, 0);
      ds = done_seen;
      step(); step();
      rst = 1'b0;
      for (int k = 0; k < 30; k++) step();
      check("arst_no_done", done_seen, ds);
      do_start(24'h400000, 24'h400000);
      wait_done("restart");
      check("restart_q", q_out, 24'h7FFF80);
      check("restart_err", err, 0);

      step(); step();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Watchdog: the bench must never hang.
   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

endmodule
`default_nettype wire
